// File: rtl/voice_pkg.sv
// Shared widths and defaults for the polyphonic tone voice allocator.
package voice_pkg;
  localparam int TONE_W = 7;
  localparam int DUR_W = 8;
  localparam logic [TONE_W-1:0] TONE_SILENT = '0;
  localparam int NVOICE_DEF = 5;
endpackage

// File: rtl/voice_slot.sv
// One tone voice: holds a tone code and counts down its remaining ticks.
module voice_slot
  import voice_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              tick_i,
  input  logic              clr_i,
  input  logic [TONE_W-1:0] tone_i,
  input  logic [DUR_W-1:0]  dur_i,
  output logic              busy_o,
  output logic [TONE_W-1:0] tone_o
);

  logic [TONE_W-1:0] tone_q, tone_d;
  logic [DUR_W-1:0]  rem_q, rem_d;

  // Load wins over the tick; the tone is dropped on the edge the count hits zero.
  always_comb begin
    tone_d = tone_q;
    rem_d  = rem_q;
    if (clr_i) begin
      tone_d = TONE_SILENT;
      rem_d  = '0;
    end else if (load_i) begin
      tone_d = tone_i;
      rem_d  = dur_i;
    end else if (tick_i && (rem_q != '0)) begin
      rem_d = rem_q - DUR_W'(1);
      if (rem_q == DUR_W'(1)) tone_d = TONE_SILENT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_q <= TONE_SILENT;
      rem_q  <= '0;
    end else begin
      tone_q <= tone_d;
      rem_q  <= rem_d;
    end
  end

  assign busy_o = (rem_q != '0);
  assign tone_o = tone_q;

endmodule

// File: rtl/voice_allocator.sv
// Assigns incoming note requests to a pool of voices: retrigger, free voice,
// or round-robin steal; a shared tick counter paces the note durations.
module voice_allocator
  import voice_pkg::*;
#(
  parameter int NVOICE   = NVOICE_DEF,
  parameter int TICK_DIV = 100000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic [TONE_W-1:0]        REQ_TONE,
  input  logic [DUR_W-1:0]         REQ_DUR,
  input  logic                     STOP_ALL,
  output logic [NVOICE*TONE_W-1:0] VOICE_TONE,
  output logic [NVOICE-1:0]        VOICE_BUSY,
  output logic                     STEAL,
  output logic [2:0]               ACTIVE_CNT
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (NVOICE > 1) ? $clog2(NVOICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NVOICE - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              steal_q, steal_d;
  logic              tick;
  logic              accept;
  logic              hit, free, use_steal;
  logic [IDX_W-1:0]  hit_idx, free_idx, tgt_idx;
  logic [NVOICE-1:0] load;
  logic [TONE_W-1:0] slot_tone [NVOICE];

  assign REQ_READY = RST && !STOP_ALL;
  assign accept    = REQ_VALID && REQ_READY && (REQ_TONE != TONE_SILENT) && (REQ_DUR != '0);

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Selection looks only at pre-edge busy flags, so a voice expiring this edge still counts as busy.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = NVOICE - 1; i >= 0; i--) begin
      if (VOICE_BUSY[i] && (slot_tone[i] == REQ_TONE)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!VOICE_BUSY[i]) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    use_steal = !hit && !free;
    tgt_idx   = hit ? hit_idx : (free ? free_idx : ptr_q);
    for (int i = 0; i < NVOICE; i++) load[i] = accept && (tgt_idx == IDX_W'(i));
  end

  always_comb begin
    ptr_d   = ptr_q;
    steal_d = accept && use_steal;
    if (STOP_ALL) ptr_d = '0;
    else if (steal_d) ptr_d = (ptr_q == IDX_LAST) ? '0 : ptr_q + IDX_W'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q   <= '0;
      ptr_q   <= '0;
      steal_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      steal_q <= steal_d;
    end
  end

  assign STEAL = steal_q;

  for (genvar g = 0; g < NVOICE; g++) begin : g_slot
    voice_slot u_slot (
      .clk    (CLK),
      .rst_n  (RST),
      .load_i (load[g]),
      .tick_i (tick),
      .clr_i  (STOP_ALL),
      .tone_i (REQ_TONE),
      .dur_i  (REQ_DUR),
      .busy_o (VOICE_BUSY[g]),
      .tone_o (slot_tone[g])
    );
    assign VOICE_TONE[g*TONE_W +: TONE_W] = slot_tone[g];
  end

  always_comb begin
    ACTIVE_CNT = '0;
    for (int i = 0; i < NVOICE; i++) ACTIVE_CNT = ACTIVE_CNT + {2'b00, VOICE_BUSY[i]};
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed checks of voice_allocator with TICK_DIV=4, NVOICE=5.
module tb_voice_allocator;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [6:0]  REQ_TONE;
  logic [7:0]  REQ_DUR;
  logic        STOP_ALL;
  logic [34:0] VOICE_TONE;
  logic [4:0]  VOICE_BUSY;
  logic        STEAL;
  logic [2:0]  ACTIVE_CNT;

  int total = 0;
  int bad = 0;

  voice_allocator #(.NVOICE(5), .TICK_DIV(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_TONE   (REQ_TONE),
    .REQ_DUR    (REQ_DUR),
    .STOP_ALL   (STOP_ALL),
    .VOICE_TONE (VOICE_TONE),
    .VOICE_BUSY (VOICE_BUSY),
    .STEAL      (STEAL),
    .ACTIVE_CNT (ACTIVE_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] pk(input int t4, input int t3, input int t2, input int t1, input int t0);
    return {7'(t4), 7'(t3), 7'(t2), 7'(t1), 7'(t0)};
  endfunction

  // One clock edge, returning at the following falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic req(input int tone, input int dur);
    REQ_VALID = 1'b1;
    REQ_TONE  = 7'(tone);
    REQ_DUR   = 8'(dur);
  endtask

  task automatic idle();
    REQ_VALID = 1'b0;
    REQ_TONE  = '0;
    REQ_DUR   = '0;
  endtask

  // Called at a falling edge; the next rising edge after return is edge 1 of the tick phase.
  task automatic do_reset();
    RST = 1'b0;
    STOP_ALL = 1'b0;
    idle();
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    STOP_ALL = 1'b0;
    idle();
    #1;
    RST = 1'b0;
    #1;
    check("rst_tone", 64'(VOICE_TONE), 64'(0));
    check("rst_busy", 64'(VOICE_BUSY), 64'(0));
    check("rst_steal", 64'(STEAL), 64'(0));
    check("rst_ready", 64'(REQ_READY), 64'(0));
    check("rst_active", 64'(ACTIVE_CNT), 64'(0));
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("ready_after_rst", 64'(REQ_READY), 64'(1));

    // Single note of two ticks: ticks land on edges 4 and 8.
    req(30, 2);
    step(1);
    idle();
    check("t1_tone", 64'(VOICE_TONE), 64'(pk(0, 0, 0, 0, 30)));
    check("t1_busy", 64'(VOICE_BUSY), 64'(5'b00001));
    check("t1_active", 64'(ACTIVE_CNT), 64'(1));
    check("t1_steal", 64'(STEAL), 64'(0));
    step(6);
    check("t1_busy_e7", 64'(VOICE_BUSY), 64'(5'b00001));
    step(1);
    check("t1_busy_e8", 64'(VOICE_BUSY), 64'(0));
    check("t1_tone_e8", 64'(VOICE_TONE), 64'(0));
    check("t1_active_e8", 64'(ACTIVE_CNT), 64'(0));
    req(0, 5);
    step(1);
    check("ign_tone0", 64'(VOICE_BUSY), 64'(0));
    req(5, 0);
    step(1);
    idle();
    check("ign_dur0", 64'(VOICE_BUSY), 64'(0));
    check("ign_steal", 64'(STEAL), 64'(0));

    // Fill all voices, then steal voice0 and voice1 in pointer order.
    do_reset();
    for (int t = 22; t <= 26; t++) begin
      req(t, 10);
      step(1);
    end
    check("t2_full_tone", 64'(VOICE_TONE), 64'(pk(26, 25, 24, 23, 22)));
    check("t2_full_steal", 64'(STEAL), 64'(0));
    req(27, 10);
    step(1);
    idle();
    check("t2_steal_tone", 64'(VOICE_TONE), 64'(pk(26, 25, 24, 23, 27)));
    check("t2_steal_pulse", 64'(STEAL), 64'(1));
    check("t2_active", 64'(ACTIVE_CNT), 64'(5));
    step(1);
    check("t2_steal_low", 64'(STEAL), 64'(0));
    req(28, 10);
    step(1);
    idle();
    check("t2_ptr1_tone", 64'(VOICE_TONE), 64'(pk(26, 25, 24, 28, 27)));
    check("t2_ptr1_steal", 64'(STEAL), 64'(1));

    // Retrigger voice2 on the edge where it would have expired.
    do_reset();
    req(10, 20); step(1);
    req(11, 20); step(1);
    req(40, 1);  step(1);
    req(40, 5);  step(1);
    idle();
    check("t3_tone", 64'(VOICE_TONE), 64'(pk(0, 0, 40, 11, 10)));
    check("t3_busy", 64'(VOICE_BUSY), 64'(5'b00111));
    check("t3_steal", 64'(STEAL), 64'(0));
    step(19);
    check("t3_busy_e23", 64'(VOICE_BUSY), 64'(5'b00111));
    step(1);
    check("t3_busy_e24", 64'(VOICE_BUSY), 64'(5'b00011));

    // Voice1 expires on the same edge as a request with every voice busy.
    do_reset();
    req(1, 50); step(1);
    req(2, 2);  step(1);
    req(3, 50); step(1);
    req(4, 50); step(1);
    req(5, 50); step(1);
    idle();
    step(2);
    check("t4_pre_busy", 64'(VOICE_BUSY), 64'(5'b11111));
    req(9, 10);
    step(1);
    idle();
    check("t4_tone", 64'(VOICE_TONE), 64'(pk(5, 4, 3, 0, 9)));
    check("t4_busy", 64'(VOICE_BUSY), 64'(5'b11101));
    check("t4_steal", 64'(STEAL), 64'(1));
    check("t4_active", 64'(ACTIVE_CNT), 64'(4));

    // STOP_ALL for one cycle with three voices sounding and a request pending.
    do_reset();
    req(5, 10); step(1);
    req(6, 10); step(1);
    req(7, 10); step(1);
    STOP_ALL = 1'b1;
    req(8, 3);
    #1;
    check("t5_ready", 64'(REQ_READY), 64'(0));
    step(1);
    check("t5_tone", 64'(VOICE_TONE), 64'(0));
    check("t5_busy", 64'(VOICE_BUSY), 64'(0));
    check("t5_steal", 64'(STEAL), 64'(0));
    check("t5_active", 64'(ACTIVE_CNT), 64'(0));
    STOP_ALL = 1'b0;
    req(12, 3);
    #1;
    check("t5_ready_back", 64'(REQ_READY), 64'(1));
    step(1);
    idle();
    check("t5_after_tone", 64'(VOICE_TONE), 64'(pk(0, 0, 0, 0, 12)));

    // Asynchronous reset in the middle of a note.
    do_reset();
    req(30, 10); step(1);
    idle();
    step(1);
    check("t6_pre_busy", 64'(VOICE_BUSY), 64'(5'b00001));
    RST = 1'b0;
    #1;
    check("t6_rst_tone", 64'(VOICE_TONE), 64'(0));
    check("t6_rst_busy", 64'(VOICE_BUSY), 64'(0));
    check("t6_rst_ready", 64'(REQ_READY), 64'(0));
    check("t6_rst_active", 64'(ACTIVE_CNT), 64'(0));
    @(negedge CLK);
    RST = 1'b1;
    req(31, 4);
    #1;
    check("t6_ready", 64'(REQ_READY), 64'(1));
    @(negedge CLK);
    idle();
    check("t6_tone", 64'(VOICE_TONE), 64'(pk(0, 0, 0, 0, 31)));
    check("t6_busy", 64'(VOICE_BUSY), 64'(5'b00001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NVOICE, default 5: number of tone voices shared.
REQ-002 SHALL have parameter TICK_DIV, default 100000: CLK cycles per duration tick.
REQ-003 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-004 SHALL have port RST  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port REQ_VALID  in  1  note request present.
REQ-006 SHALL have port REQ_READY  out  1  request can be accepted this cycle.
REQ-007 SHALL have port REQ_TONE  in  7  tone code; 0 is rest/silent.
REQ-008 SHALL have port REQ_DUR  in  8  note length in ticks.
REQ-009 SHALL have port STOP_ALL  in  1  silence all voices.
REQ-010 SHALL have port VOICE_TONE  out  NVOICE*7  per-voice tone; voice i at bits [7i+6:7i]; 0 = silent.
REQ-011 SHALL have port VOICE_BUSY  out  NVOICE  per-voice sounding flag.
REQ-012 SHALL have port STEAL  out  1  one-cycle pulse: last accept evicted a busy voice.
REQ-013 SHALL have port ACTIVE_CNT  out  3  number of busy voices.

Function
REQ-014 SHALL run a tick counter 0..TICK_DIV-1, asserting internal tick for one cycle at TICK_DIV-1, then wrapping to 0.
REQ-015 SHALL drive REQ_READY = !STOP_ALL outside reset.
REQ-016 SHALL accept a request on a rising edge where REQ_VALID && REQ_READY; results visible the following cycle (1-cycle latency).
REQ-017 SHALL accept but ignore requests with REQ_TONE==0 or REQ_DUR==0 (no voice change, no STEAL).
REQ-018 SHALL choose the target voice by priority: busy voice with equal tone (retrigger) > lowest-index free voice > voice at steal pointer.
REQ-019 SHALL, on accept, load target voice tone=REQ_TONE, remaining=REQ_DUR, busy=1.
REQ-020 SHALL, only when the steal path is used, pulse STEAL and advance the steal pointer modulo NVOICE (NVOICE-1 wraps to 0).
REQ-021 SHALL on each tick decrement remaining of every busy voice not loaded that edge; a voice reaching 0 clears busy and tone on the same edge.
REQ-022 SHALL base voice selection on pre-edge state: a voice expiring on the same edge is not treated as free.
REQ-023 SHALL give an accept priority over the tick for the loaded voice (remaining=REQ_DUR, no decrement).
REQ-024 SHALL, while STOP_ALL is high, synchronously clear all tones, busy, remaining and steal pointer each edge; the tick counter keeps running.
REQ-025 SHALL drive ACTIVE_CNT combinationally as popcount(VOICE_BUSY).
REQ-026 SHALL keep VOICE_TONE[i]==0 exactly when VOICE_BUSY[i]==0.

Reset
REQ-027 SHALL, while RST is low, force VOICE_TONE=0, VOICE_BUSY=0, STEAL=0, REQ_READY=0, tick counter=0, steal pointer=0, all remaining=0.
REQ-028 SHALL honour reset asynchronously, including mid-note; REQ_READY rises combinationally with RST release if STOP_ALL is low.

Structure
REQ-029 SHALL place TONE_W=7, DUR_W=8, TONE_SILENT=0 and default NVOICE in shared package voice_pkg.
REQ-030 SHALL implement one sub-module voice_slot (tone register, duration counter, load/tick/clear inputs, busy/tone outputs), instantiated NVOICE times.
REQ-031 SHALL keep selection, steal pointer and tick generation in voice_allocator.

Verification (TICK_DIV=4, NVOICE=5)
REQ-032 SHALL cover: accept tone 30 dur 2 -> voice0 tone 30 next cycle, busy=00001, cleared after 2nd tick, ACTIVE_CNT 1->0.
REQ-033 SHALL cover: six requests tones 22..27 dur 10 back-to-back -> voices 0..4 filled, 6th (27) replaces voice0, STEAL pulse once, pointer=1.
REQ-034 SHALL cover: retrigger tone 40 while voice2 plays 40 with remaining 1 -> voice2 reloaded, no new voice, no STEAL.
REQ-035 SHALL cover: accept on same edge voice1 expires, all others busy -> steal path used, voice1 not reused that edge.
REQ-036 SHALL cover: STOP_ALL one cycle with 3 voices busy and REQ_VALID high -> REQ_READY=0, all tones 0, no accept.
REQ-037 SHALL cover: RST low mid-note for 1 cycle -> all outputs 0 immediately, normal accept on first edge after release.
